// File: rtl/tx_bank_arbiter.sv
// Ping-pong TX buffer controller: allocates two banks to the packet writer, records
// committed packet lengths and presents finished packets to the reader in commit order.
module tx_bank_arbiter #(
  parameter int unsigned ADDR_NBIT = 8,
  parameter int unsigned DATA_NBIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 wr_rdy,
  input  logic                 wr_vd,
  input  logic [DATA_NBIT-1:0] wr_data,
  input  logic                 wr_eop,
  output logic                 ram_wren,
  output logic [ADDR_NBIT:0]   ram_wraddr,
  output logic [DATA_NBIT-1:0] ram_wrdata,
  output logic                 rd_pkt_vd,
  output logic [ADDR_NBIT:0]   rd_pkt_len,
  output logic                 rd_bank,
  input  logic                 rd_done,
  output logic [1:0]           tx_pend,
  output logic                 err_ovf,
  output logic                 err_drop
);

  typedef enum logic [1:0] {BkFree, BkFilling, BkFull} bank_st_e;

  bank_st_e               bank_q [2];
  logic [ADDR_NBIT:0]     len_q  [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [ADDR_NBIT-1:0]   wcnt;
  logic                   accept;
  logic                   last;
  logic                   done;

  assign wr_rdy  = (bank_q[wr_ptr] != BkFull);
  assign accept  = wr_vd & wr_rdy;
  // A word landing in the last slot closes the packet whether or not it carries eop.
  assign last    = accept & (wr_eop | (&wcnt));
  assign done    = rd_done & rd_pkt_vd;
  assign tx_pend = {1'b0, bank_q[0] == BkFull} + {1'b0, bank_q[1] == BkFull};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]  <= BkFree;
      bank_q[1]  <= BkFree;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      wcnt       <= '0;
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_wrdata <= '0;
      rd_pkt_vd  <= 1'b0;
      rd_pkt_len <= '0;
      rd_bank    <= 1'b0;
      err_ovf    <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      ram_wren <= accept;
      err_drop <= wr_vd & ~wr_rdy;
      err_ovf  <= accept & ~wr_eop & (&wcnt);
      if (accept) begin
        ram_wraddr <= {wr_ptr, wcnt};
        ram_wrdata <= wr_data;
        if (last) begin
          bank_q[wr_ptr] <= BkFull;
          len_q[wr_ptr]  <= {1'b0, wcnt} + 1'b1;
          wr_ptr         <= ~wr_ptr;
          wcnt           <= '0;
        end else begin
          bank_q[wr_ptr] <= BkFilling;
          wcnt           <= wcnt + 1'b1;
        end
      end
      // The writer only touches a non-full bank and the reader only a full one, so the
      // two bank updates below never collide.
      if (done) begin
        bank_q[rd_ptr] <= BkFree;
        rd_ptr         <= ~rd_ptr;
        rd_pkt_vd      <= 1'b0;
      end else if (!rd_pkt_vd && bank_q[rd_ptr] == BkFull) begin
        // Registered one edge after commit so the last word is already in RAM.
        rd_pkt_vd  <= 1'b1;
        rd_bank    <= rd_ptr;
        rd_pkt_len <= len_q[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_tx_bank_arbiter.sv
// Directed bench for tx_bank_arbiter: a vector table for the basic packet flow plus
// hand-written sequences for dual-bank, overflow, simultaneous and reset cases.
module tb_tx_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wr_rdy;
  logic        wr_vd;
  logic [15:0] wr_data;
  logic        wr_eop;
  logic        ram_wren;
  logic [8:0]  ram_wraddr;
  logic [15:0] ram_wrdata;
  logic        rd_pkt_vd;
  logic [8:0]  rd_pkt_len;
  logic        rd_bank;
  logic        rd_done;
  logic [1:0]  tx_pend;
  logic        err_ovf;
  logic        err_drop;

  int checks = 0;
  int errors = 0;

  tx_bank_arbiter #(.ADDR_NBIT(8), .DATA_NBIT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_rdy     (wr_rdy),
    .wr_vd      (wr_vd),
    .wr_data    (wr_data),
    .wr_eop     (wr_eop),
    .ram_wren   (ram_wren),
    .ram_wraddr (ram_wraddr),
    .ram_wrdata (ram_wrdata),
    .rd_pkt_vd  (rd_pkt_vd),
    .rd_pkt_len (rd_pkt_len),
    .rd_bank    (rd_bank),
    .rd_done    (rd_done),
    .tx_pend    (tx_pend),
    .err_ovf    (err_ovf),
    .err_drop   (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vd;
    logic        eop;
    logic [15:0] data;
    logic        done;
    logic        e_wren;
    logic [8:0]  e_addr;
    logic        e_vd;
    logic        e_bank;
    logic [8:0]  e_len;
    logic [1:0]  e_pend;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " wr_rdy"}, 32'(wr_rdy), 32'd1);
    chk({tag, " rd_pkt_vd"}, 32'(rd_pkt_vd), 32'd0);
    chk({tag, " rd_pkt_len"}, 32'(rd_pkt_len), 32'd0);
    chk({tag, " rd_bank"}, 32'(rd_bank), 32'd0);
    chk({tag, " ram_wren"}, 32'(ram_wren), 32'd0);
    chk({tag, " ram_wraddr"}, 32'(ram_wraddr), 32'd0);
    chk({tag, " ram_wrdata"}, 32'(ram_wrdata), 32'd0);
    chk({tag, " tx_pend"}, 32'(tx_pend), 32'd0);
    chk({tag, " err_ovf"}, 32'(err_ovf), 32'd0);
    chk({tag, " err_drop"}, 32'(err_drop), 32'd0);
  endtask

  task automatic do_reset();
    wr_vd   = 1'b0;
    wr_eop  = 1'b0;
    wr_data = '0;
    rd_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One accepted word: drive, take the edge, check the registered write.
  task automatic put(input logic [15:0] d, input logic eop, input logic [8:0] exp_addr);
    wr_vd   = 1'b1;
    wr_data = d;
    wr_eop  = eop;
    tick();
    chk("put wren", 32'(ram_wren), 32'd1);
    chk("put addr", 32'(ram_wraddr), 32'(exp_addr));
    chk("put data", 32'(ram_wrdata), 32'(d));
    wr_vd  = 1'b0;
    wr_eop = 1'b0;
  endtask

  task automatic chk_present(input string tag, input logic bank, input logic [8:0] len);
    chk({tag, " vd"}, 32'(rd_pkt_vd), 32'd1);
    chk({tag, " bank"}, 32'(rd_bank), 32'(bank));
    chk({tag, " len"}, 32'(rd_pkt_len), 32'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    vecs[0] = '{1'b1, 1'b0, 16'hA000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 16'hA001, 1'b0, 1'b1, 9'h001, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'hA002, 1'b0, 1'b1, 9'h002, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 16'hA003, 1'b0, 1'b1, 9'h003, 1'b0, 1'b0, 9'd0, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'd4, 2'd1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1};

    do_reset();

    // Single 4-word packet, read back, then an ignored rd_done.
    for (int i = 0; i < 7; i++) begin
      wr_vd   = vecs[i].vd;
      wr_eop  = vecs[i].eop;
      wr_data = vecs[i].data;
      rd_done = vecs[i].done;
      tick();
      chk($sformatf("v%0d wren", i), 32'(ram_wren), 32'(vecs[i].e_wren));
      if (vecs[i].e_wren) begin
        chk($sformatf("v%0d addr", i), 32'(ram_wraddr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d data", i), 32'(ram_wrdata), 32'(vecs[i].data));
      end
      chk($sformatf("v%0d rd_pkt_vd", i), 32'(rd_pkt_vd), 32'(vecs[i].e_vd));
      if (vecs[i].e_vd) begin
        chk($sformatf("v%0d rd_bank", i), 32'(rd_bank), 32'(vecs[i].e_bank));
        chk($sformatf("v%0d rd_len", i), 32'(rd_pkt_len), 32'(vecs[i].e_len));
      end
      chk($sformatf("v%0d tx_pend", i), 32'(tx_pend), 32'(vecs[i].e_pend));
      chk($sformatf("v%0d wr_rdy", i), 32'(wr_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d err_drop", i), 32'(err_drop), 32'd0);
    end
    wr_vd   = 1'b0;
    rd_done = 1'b0;

    // Two packets, both banks full, then dropped words.
    do_reset();
    for (int i = 0; i < 10; i++) put(16'h1000 + 16'(i), (i == 9), 9'(i));
    for (int i = 0; i < 3; i++) put(16'h2000 + 16'(i), (i == 2), 9'h100 + 9'(i));
    chk("full tx_pend", 32'(tx_pend), 32'd2);
    chk("full wr_rdy", 32'(wr_rdy), 32'd0);
    wr_vd   = 1'b1;
    wr_data = 16'hDEAD;
    tick();
    chk("drop1 err_drop", 32'(err_drop), 32'd1);
    chk("drop1 wren", 32'(ram_wren), 32'd0);
    tick();
    chk("drop2 err_drop", 32'(err_drop), 32'd1);
    chk("drop2 wren", 32'(ram_wren), 32'd0);
    wr_vd = 1'b0;
    tick();
    chk("drop3 err_drop", 32'(err_drop), 32'd0);
    chk("drop tx_pend", 32'(tx_pend), 32'd2);
    chk_present("two p0", 1'b0, 9'd10);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("two gap vd", 32'(rd_pkt_vd), 32'd0);
    chk("two tx_pend", 32'(tx_pend), 32'd1);
    chk("two wr_rdy", 32'(wr_rdy), 32'd1);
    tick();
    chk_present("two p1", 1'b1, 9'd3);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("two end tx_pend", 32'(tx_pend), 32'd0);

    // Overflow: 300 words split into 256 + 44.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      put(16'(i), (i == 299), (i < 256) ? 9'(i) : 9'h100 + 9'(i - 256));
      chk($sformatf("ovf w%0d err_ovf", i), 32'(err_ovf), 32'(i == 255));
    end
    chk("ovf tx_pend", 32'(tx_pend), 32'd2);
    chk("ovf wr_rdy", 32'(wr_rdy), 32'd0);
    tick();
    chk_present("ovf p0", 1'b0, 9'd256);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    chk_present("ovf p1", 1'b1, 9'd44);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;

    // Commit on bank1 coincides with rd_done of bank0.
    do_reset();
    put(16'h3000, 1'b0, 9'h000);
    put(16'h3001, 1'b1, 9'h001);
    tick();
    chk_present("sim p0", 1'b0, 9'd2);
    put(16'h4000, 1'b0, 9'h100);
    rd_done = 1'b1;
    put(16'h4001, 1'b1, 9'h101);
    rd_done = 1'b0;
    chk("sim tx_pend", 32'(tx_pend), 32'd1);
    chk("sim vd low", 32'(rd_pkt_vd), 32'd0);
    chk("sim wr_rdy", 32'(wr_rdy), 32'd1);
    tick();
    chk_present("sim p1", 1'b1, 9'd2);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("sim end tx_pend", 32'(tx_pend), 32'd0);

    // rd_done with nothing presented, then async reset mid-packet.
    do_reset();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("idle done tx_pend", 32'(tx_pend), 32'd0);
    chk("idle done vd", 32'(rd_pkt_vd), 32'd0);
    put(16'h5000, 1'b1, 9'h000);
    tick();
    chk_present("idle p0", 1'b0, 9'd1);
    for (int i = 0; i < 5; i++) put(16'h6000 + 16'(i), 1'b0, 9'h100 + 9'(i));
    wr_vd   = 1'b1;
    wr_data = 16'h6005;
    #3 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    wr_vd = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_vals("postrst");
    put(16'h7000, 1'b1, 9'h000);
    tick();
    chk_present("postrst p0", 1'b0, 9'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
